// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS multicycle control definitions: FSM state codes, opcode/funct
// constants and ALUop/mux select codes (also consumed by the ALU control block).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR  = 6'b001000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_listed_op(input logic [5:0] op);
    logic listed;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW: listed = 1'b1;
      default:                                                listed = 1'b0;
    endcase
    return listed;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; expired flags the configured limit.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] count,
  output logic       expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_WAIT_MAX);

  logic [7:0] count_q, count_d;

  // Next count: clear has priority over increment
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath with memory-wait timeout.
// Define MCU_ILLEGAL_OP_EN to add the sticky illegal_op output.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic [1:0] ALUop,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       mem_timeout
`ifdef MCU_ILLEGAL_OP_EN
  ,
  output logic       illegal_op
`endif
);

  state_e     state_q, state_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic [7:0] wait_count_s;
  logic       expired_s, waiting_s, timeout_s, clr_s, en_s;

  assign waiting_s = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  // Completion in the expiry cycle wins, so timeout needs mem_ready low
  assign timeout_s = waiting_s && !mem_ready && expired_s;
  assign en_s      = waiting_s && !mem_ready && (wait_count_s != 8'hFF);
  assign clr_s     = (state_d != state_q) || timeout_s;

  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_s),
    .en     (en_s),
    .count  (wait_count_s),
    .expired(expired_s)
  );

  // Next-state selection
  always_comb begin
    state_d       = state_q;
    mem_timeout_d = timeout_s;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_RTYPE:         state_d = S_R_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEM_READ;
        end else if (opcode == OP_SW) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_READ: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_WRITE: state_d = (mem_ready || timeout_s) ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = (funct == FUNCT_JR) ? S_FETCH : S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  // State and timeout pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Moore output decode; FETCH write strobes are qualified by reset
  always_comb begin
    ALUop       = ALUOP_ADD;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready && rst_n;
        PCWrite = mem_ready && rst_n;
      end
      S_DECODE:    ALUSrcB = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUop   = (opcode == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_I_WB:      RegWrite = 1'b1;
      default:     ALUop = ALUOP_ADD;
    endcase
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;

`ifdef MCU_ILLEGAL_OP_EN
  logic illegal_op_q, illegal_op_d;

  // Sticky flag for opcodes DECODE does not recognise
  always_comb begin
    illegal_op_d = illegal_op_q;
    if ((state_q == S_DECODE) && !is_listed_op(opcode)) begin
      illegal_op_d = 1'b1;
    end else begin
      illegal_op_d = illegal_op_q;
    end
  end

  // Illegal-op register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op_q <= 1'b0;
    end else begin
      illegal_op_q <= illegal_op_d;
    end
  end

  assign illegal_op = illegal_op_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: instruction-level reference model builds the expected
// per-cycle trace (state, controls, timeout pulse) for random and directed programs.
module tb_multicycle_control_unit;

  localparam int MAXW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic [1:0] ALUop, ALUSrcB, PCSource;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, mem_timeout;
  logic [3:0] state;
`ifdef MCU_ILLEGAL_OP_EN
  logic       illegal_op;
`endif

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_unit #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .ALUop(ALUop), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .state(state), .mem_timeout(mem_timeout)
`ifdef MCU_ILLEGAL_OP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] dut_ctrl;
  assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource};

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       tmo;
    logic       ill;
  } ent_t;

  ent_t q[$];
  logic pend_tmo = 1'b0;
  logic model_ill = 1'b0;
  logic [5:0] cur_op, cur_fn;

  // Expected datapath controls for a state, from the state description table
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                           input logic [5:0] op);
    logic pcw = 1'b0, pcwc = 1'b0, iord = 1'b0, mrd = 1'b0, mwr = 1'b0, irw = 1'b0;
    logic m2r = 1'b0, rdst = 1'b0, rwr = 1'b0, asa = 1'b0;
    logic [1:0] asb = 2'd0, aop = 2'd0, psrc = 2'd0;
    case (st)
      4'd0:  begin mrd = 1'b1; asb = 2'd1; irw = rdy; pcw = rdy; end
      4'd1:  asb = 2'd3;
      4'd2:  begin asa = 1'b1; asb = 2'd2; end
      4'd3:  begin mrd = 1'b1; iord = 1'b1; end
      4'd4:  begin rwr = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = 1'b1; iord = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'd2; end
      4'd7:  begin rwr = 1'b1; rdst = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'd1; pcwc = 1'b1; psrc = 2'd1; end
      4'd9:  begin pcw = 1'b1; psrc = 2'd2; end
      4'd10: begin asa = 1'b1; asb = 2'd2; aop = (op == 6'b001100) ? 2'd3 : 2'd0; end
      4'd11: rwr = 1'b1;
      default: pcw = 1'b0;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, psrc};
  endfunction

  function automatic void push(input logic [3:0] st, input logic rdy);
    ent_t e;
    e.st = st; e.rdy = rdy; e.tmo = pend_tmo; e.ill = model_ill;
    pend_tmo = 1'b0;
    q.push_back(e);
  endfunction

  // Memory wait of L idle cycles; returns 0 when the access times out
  function automatic logic add_wait(input logic [3:0] st, input int lat);
    for (int k = 0; k <= MAXW; k++) begin
      if (k == lat) begin
        push(st, 1'b1);
        return 1'b1;
      end
      push(st, 1'b0);
    end
    pend_tmo = 1'b1;
    return 1'b0;
  endfunction

  function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                input int lf, input int lm);
    if (!add_wait(4'd0, lf)) return;
    push(4'd1, 1'b0);
    case (op)
      6'b100011: begin push(4'd2, 1'b0); if (add_wait(4'd3, lm)) push(4'd4, 1'b0); end
      6'b101011: begin push(4'd2, 1'b0); void'(add_wait(4'd5, lm)); end
      6'b000000: begin push(4'd6, 1'b0); if (fn != 6'b001000) push(4'd7, 1'b0); end
      6'b000100: push(4'd8, 1'b0);
      6'b000010: push(4'd9, 1'b0);
      6'b001000, 6'b001100: begin push(4'd10, 1'b0); push(4'd11, 1'b0); end
      default: model_ill = 1'b1;
    endcase
  endfunction

  // Plays up to n expected cycles; entered and left on a falling edge
  task automatic play(input string name, input int n);
    int lim = (n < q.size()) ? n : q.size();
    for (int i = 0; i < lim; i++) begin
      mem_ready = q[i].rdy;
      opcode = cur_op;
      funct = cur_fn;
      #1;
      n_checks++;
      if (state !== q[i].st) begin
        n_errors++;
        $display("FAIL %s state cyc%0d: got %0d expected %0d", name, i, state, q[i].st);
      end
      n_checks++;
      if (dut_ctrl !== exp_ctrl(q[i].st, q[i].rdy, cur_op)) begin
        n_errors++;
        $display("FAIL %s ctrl cyc%0d st%0d: got %b expected %b", name, i, q[i].st,
                 dut_ctrl, exp_ctrl(q[i].st, q[i].rdy, cur_op));
      end
      n_checks++;
      if (mem_timeout !== q[i].tmo) begin
        n_errors++;
        $display("FAIL %s mem_timeout cyc%0d: got %b expected %b", name, i, mem_timeout, q[i].tmo);
      end
`ifdef MCU_ILLEGAL_OP_EN
      n_checks++;
      if (illegal_op !== q[i].ill) begin
        n_errors++;
        $display("FAIL %s illegal_op cyc%0d: got %b expected %b", name, i, illegal_op, q[i].ill);
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int lf, input int lm);
    q.delete();
    cur_op = op;
    cur_fn = fn;
    build(op, fn, lf, lm);
    play(name, q.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_errors++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    n_checks++;
    if (dut_ctrl !== exp_ctrl(4'd0, 1'b0, 6'd0)) begin
      n_errors++; $display("FAIL reset_ctrl: got %b expected %b", dut_ctrl, exp_ctrl(4'd0, 1'b0, 6'd0));
    end
    n_checks++;
    if (mem_timeout !== 1'b0) begin
      n_errors++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pend_tmo = 1'b0;
    model_ill = 1'b0;
  endtask

  task automatic test_directed();
    run_instr("lw", 6'b100011, 6'd0, 0, 0);
    run_instr("add", 6'b000000, 6'b100000, 1, 0);
    run_instr("jr", 6'b000000, 6'b001000, 0, 0);
    run_instr("beq", 6'b000100, 6'd0, 0, 0);
    run_instr("andi", 6'b001100, 6'd0, 2, 0);
    run_instr("addi", 6'b001000, 6'd0, 0, 0);
    run_instr("j", 6'b000010, 6'd0, 0, 0);
    run_instr("sw", 6'b101011, 6'd0, 0, 1);
  endtask

  task automatic test_timeout();
    run_instr("fetch_timeout", 6'b100011, 6'd0, 9, 0);
    run_instr("fetch_at_limit", 6'b000010, 6'd0, MAXW, 0);
    run_instr("lw_read_timeout", 6'b100011, 6'd0, 0, 7);
    run_instr("sw_at_limit", 6'b101011, 6'd0, 0, MAXW);
    run_instr("sw_write_timeout", 6'b101011, 6'd0, 1, 5);
    run_instr("after_timeout", 6'b000100, 6'd0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 6'b111111, 6'd0, 0, 0);
    run_instr("after_illegal", 6'b001000, 6'd0, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b001100, 6'b010101};
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
      run_instr("random", op, fn, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end
    run_instr("random_tail", 6'b000010, 6'd0, 0, 0);
  endtask

  task automatic test_async_reset();
    q.delete();
    cur_op = 6'b101011;
    cur_fn = 6'd0;
    build(6'b101011, 6'd0, 0, 3);
    play("sw_pre_reset", 4);
    mem_ready = 1'b0;
    @(posedge clk);
    #2;
    n_checks++;
    if (state !== 4'd5) begin
      n_errors++; $display("FAIL async_pre_state: got %0d expected 5", state);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_errors++; $display("FAIL async_state: got %0d expected 0", state);
    end
    n_checks++;
    if (MemWrite !== 1'b0 || IRWrite !== 1'b0 || RegWrite !== 1'b0) begin
      n_errors++; $display("FAIL async_writes: got MemWrite=%b IRWrite=%b RegWrite=%b expected 0", MemWrite, IRWrite, RegWrite);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pend_tmo = 1'b0;
    model_ill = 1'b0;
    run_instr("post_reset_lw", 6'b100011, 6'd0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_timeout();
    test_illegal();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
